simplex_pivot_sel: RTL
======================

# simplex_pivot_sel

Pivot-selection engine for the parametrised simplex datapath. On `start_i` it scans the objective row of an externally stored IEEE-754 tableau to choose the entering column. It then runs the minimum-ratio test over the constraint rows through an external shared FP divider and reports the pivot (row, column), or reports that the problem is optimal or unbounded. It sits between the tableau RAM and the pivot/row-update unit of the solver, replacing the fixed 2×1×1 tableau sizing with run-time dimensions up to the parameter maxima.

## Interface
- `EXP_W`, 8, float exponent width
- `MAN_W`, 23, float mantissa width; `DATA_WIDTH` = 1+`EXP_W`+`MAN_W`
- `NROWSMAX`, 8, max constraint rows; objective row index = `nrows_i`
- `NCOLSMAX`, 16, max columns including RHS (last column, index `ncols_i`-1)
- `clk_i` in 1: single clock, rising edge
- `rstn_i` in 1: reset, asynchronous, active-low
- `start_i` in 1: start request, sampled in IDLE only
- `nrows_i` in $clog2(NROWSMAX+1): constraint rows, sampled with start
- `ncols_i` in $clog2(NCOLSMAX+1): columns incl. RHS, sampled with start
- `rd_en_o` out 1: tableau read strobe
- `rd_row_o` out $clog2(NROWSMAX+1): read row
- `rd_col_o` out $clog2(NCOLSMAX): read column
- `rd_data_i` in DATA_WIDTH: read data, valid exactly 1 cycle after `rd_en_o`
- `div_req_o` out 1: divide request, held until ack
- `div_a_o`, `div_b_o` out DATA_WIDTH: dividend (RHS), divisor (column entry)
- `div_ack_i` in 1: divider done; `div_q_i` valid in the same cycle
- `div_q_i` in DATA_WIDTH: quotient
- `busy_o` out 1: high from the cycle after accepted start until done
- `done_o` out 1: one-cycle completion pulse
- `status_o` out 2: 0 PIVOT, 1 OPTIMAL, 2 UNBOUNDED, 3 BADDIM
- `pivot_row_o` out $clog2(NROWSMAX+1), `pivot_col_o` out $clog2(NCOLSMAX): result

## Operation
- Float ordering uses a sortable key: negative → bitwise NOT; non-negative → flip sign bit. Then do unsigned compare. -0 and +0 are both zero. NaN/Inf inputs are unsupported.
- "Negative" means sign=1 and magnitude≠0. "Positive" means sign=0 and magnitude≠0.
- States: IDLE → (dims check) → CSCAN → CLAST → RRDA → RRDB → RCHK → [RDIV] → … → DONE → IDLE.
- BADDIM: `nrows_i`==0, `ncols_i`<2, or either exceeds its max. Result is status 3, with `done_o` in the cycle after start and no reads issued.
- CSCAN: reads row `nrows_i`, columns 0..`ncols_i`-2, one per cycle, pipelined. The compare happens on returned data. Entering column = most negative entry; ties go to the lowest index (strict less-than replaces).
- No negative entry: status OPTIMAL, `pivot_col_o`=0, `pivot_row_o`=0, and the row scan is skipped.
- Row r = 0..`nrows_i`-1:
  - RRDA reads (r, col).
  - RRDB reads (r, `ncols_i`-1) and captures a.
  - RCHK captures b.
  - If a is positive: RDIV drives `div_a_o`=b, `div_b_o`=a, holding `div_req_o`=1 until `div_ack_i`. The quotient replaces the best if it is strictly smaller, or if it is the first candidate.
  - Otherwise the row is skipped.
- After the last row: status PIVOT with the best row, or UNBOUNDED (`pivot_row_o`=0) if no positive a was found.
- Results and status hold from `done_o` until the next accepted start.
- `start_i` is ignored while busy.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset mid-operation aborts immediately: `div_req_o` and `rd_en_o` drop asynchronously and no `done_o` is issued. The divider must tolerate a withdrawn request.
- Start accepted at edge T: `busy_o`=1 and the first `rd_en_o` at T+1. CSCAN issues `ncols_i`-1 consecutive strobes. The final compare is in CLAST.
- OPTIMAL: `done_o` at T+`ncols_i`+1.
- Per row: 3 cycles if a is not positive; 3+D+1 cycles with divider latency D (ack in the D-th cycle of request). `div_req_o` drops the cycle after ack.
- `done_o` coincides with `busy_o` falling. A new start is accepted the cycle after `done_o`.
- `div_ack_i` without a request is ignored. `rd_data_i` is ignored except in capture cycles.

## Test plan
- Objective row [-3,-5,0,0,0] (0xC0400000, 0xC0A00000), rows [1,0,1,0,4], [0,2,0,1,12], [3,2,0,0,18], nrows=3, ncols=5, D=1 → col 1, rows 1 and 2 divided (6, 9), PIVOT row 1, `done_o` at the expected cycle.
- Objective row [-2,-2,0,0], ratios equal (8/2, 8/2) → col 0, row 0 (lowest-index ties); -0.0 entry in the objective is never chosen.
- Objective row [0,1,-0.0,2,7] → OPTIMAL at T+6, no `div_req_o` ever asserted.
- Entering column entries {0,-1,-0.0} in all rows → UNBOUNDED, zero divides.
- Divider stalls 5 cycles with `start_i` re-pulsed mid-run → `div_req_o` held stable, start ignored, correct PIVOT. Then `rstn_i` low during RDIV of a second run → all outputs 0 asynchronously, no `done_o`.
- nrows=0, then ncols=1, then ncols=NCOLSMAX+1 → BADDIM each with `done_o` at T+1 and no `rd_en_o`.

Source files
------------

// File: rtl/simplex_pivot_sel.sv
// simplex_pivot_sel: picks the entering column (most negative objective entry) and then the
// leaving row by minimum-ratio test over an external IEEE-754 tableau, using a shared divider.
module simplex_pivot_sel #(
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned MAN_W    = 23,
  parameter int unsigned NROWSMAX = 8,
  parameter int unsigned NCOLSMAX = 16,
  localparam int unsigned DATA_WIDTH = 1 + EXP_W + MAN_W,
  localparam int unsigned RW         = $clog2(NROWSMAX + 1),
  localparam int unsigned CW         = $clog2(NCOLSMAX),
  localparam int unsigned NCW        = $clog2(NCOLSMAX + 1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [RW-1:0]         nrows_i,
  input  logic [NCW-1:0]        ncols_i,
  output logic                  rd_en_o,
  output logic [RW-1:0]         rd_row_o,
  output logic [CW-1:0]         rd_col_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  div_req_o,
  output logic [DATA_WIDTH-1:0] div_a_o,
  output logic [DATA_WIDTH-1:0] div_b_o,
  input  logic                  div_ack_i,
  input  logic [DATA_WIDTH-1:0] div_q_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            status_o,
  output logic [RW-1:0]         pivot_row_o,
  output logic [CW-1:0]         pivot_col_o
);

  localparam logic [1:0] StatPivot     = 2'd0;
  localparam logic [1:0] StatOptimal   = 2'd1;
  localparam logic [1:0] StatUnbounded = 2'd2;
  localparam logic [1:0] StatBadDim    = 2'd3;

  localparam logic [DATA_WIDTH-1:0] SignBit = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    StIdle, StCscan, StClast, StRrda, StRrdb, StRchk, StRdiv, StRnxt, StDone
  } state_e;

  // Unsigned-comparable key; both zeros share one key so -0 and +0 compare equal.
  function automatic logic [DATA_WIDTH-1:0] sort_key(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] k;
    if (x[DATA_WIDTH-2:0] == '0)  k = SignBit;
    else if (x[DATA_WIDTH-1])     k = ~x;
    else                          k = x ^ SignBit;
    return k;
  endfunction

  function automatic logic is_neg(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] && (x[DATA_WIDTH-2:0] != '0);
  endfunction

  function automatic logic is_pos(input logic [DATA_WIDTH-1:0] x);
    return !x[DATA_WIDTH-1] && (x[DATA_WIDTH-2:0] != '0);
  endfunction

  state_e                state_q;
  logic [RW-1:0]         nrows_q, rd_row_q, best_row_q, pivot_row_q;
  logic [NCW-1:0]        ncols_q;
  logic [CW-1:0]         rd_col_q, cmp_col_q, best_col_q, pivot_col_q;
  logic                  rd_en_q, cmp_vld_q, cfound_q, rfound_q;
  logic                  div_req_q, busy_q, done_q;
  logic [DATA_WIDTH-1:0] ckey_q, rkey_q, a_q, div_a_q, div_b_q;
  logic [1:0]            status_q;

  logic          bad_dim, col_take, q_take, a_pos, last_scan, last_row, advance;
  logic [CW-1:0] col_final;

  assign bad_dim   = (nrows_i == '0) || (32'(nrows_i) > NROWSMAX) ||
                     (ncols_i < NCW'(2)) || (32'(ncols_i) > NCOLSMAX);
  // Strict less-than keeps the lowest index on ties.
  assign col_take  = is_neg(rd_data_i) && (!cfound_q || (sort_key(rd_data_i) < ckey_q));
  assign col_final = col_take ? cmp_col_q : best_col_q;
  assign q_take    = !rfound_q || (sort_key(div_q_i) < rkey_q);
  assign a_pos     = is_pos(a_q);
  assign last_scan = (NCW'(rd_col_q) == ncols_q - NCW'(2));
  assign last_row  = (rd_row_q == nrows_q - RW'(1));
  assign advance   = ((state_q == StRchk) && !a_pos) || (state_q == StRnxt);

  // Control FSM with registered outputs; async reset withdraws read and divide requests.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      nrows_q     <= '0;
      ncols_q     <= '0;
      rd_en_q     <= 1'b0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_col_q   <= '0;
      cfound_q    <= 1'b0;
      ckey_q      <= '0;
      best_col_q  <= '0;
      a_q         <= '0;
      div_req_q   <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      rfound_q    <= 1'b0;
      rkey_q      <= '0;
      best_row_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= '0;
      pivot_row_q <= '0;
      pivot_col_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            nrows_q <= nrows_i;
            ncols_q <= ncols_i;
            if (bad_dim) begin
              status_q    <= StatBadDim;
              pivot_row_q <= '0;
              pivot_col_q <= '0;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end else begin
              busy_q    <= 1'b1;
              rd_en_q   <= 1'b1;
              rd_row_q  <= nrows_i;
              rd_col_q  <= '0;
              cmp_vld_q <= 1'b0;
              cfound_q  <= 1'b0;
              state_q   <= StCscan;
            end
          end
        end
        StCscan: begin
          if (cmp_vld_q && col_take) begin
            cfound_q   <= 1'b1;
            ckey_q     <= sort_key(rd_data_i);
            best_col_q <= cmp_col_q;
          end
          cmp_vld_q <= 1'b1;
          cmp_col_q <= rd_col_q;
          if (last_scan) begin
            rd_en_q <= 1'b0;
            state_q <= StClast;
          end else begin
            rd_col_q <= rd_col_q + CW'(1);
          end
        end
        StClast: begin
          if (!(cfound_q || col_take)) begin
            status_q    <= StatOptimal;
            pivot_row_q <= '0;
            pivot_col_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end else begin
            best_col_q <= col_final;
            rd_en_q    <= 1'b1;
            rd_row_q   <= '0;
            rd_col_q   <= col_final;
            rfound_q   <= 1'b0;
            state_q    <= StRrda;
          end
        end
        StRrda: begin
          rd_col_q <= CW'(ncols_q - NCW'(1));
          state_q  <= StRrdb;
        end
        StRrdb: begin
          rd_en_q <= 1'b0;
          a_q     <= rd_data_i;
          state_q <= StRchk;
        end
        StRchk: begin
          if (a_pos) begin
            div_req_q <= 1'b1;
            div_a_q   <= rd_data_i;
            div_b_q   <= a_q;
            state_q   <= StRdiv;
          end
        end
        StRdiv: begin
          if (div_ack_i) begin
            div_req_q <= 1'b0;
            if (q_take) begin
              rfound_q   <= 1'b1;
              rkey_q     <= sort_key(div_q_i);
              best_row_q <= rd_row_q;
            end
            state_q <= StRnxt;
          end
        end
        StRnxt: ;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      // Shared row-advance path for skipped rows and finished divides.
      if (advance) begin
        if (last_row) begin
          status_q    <= rfound_q ? StatPivot : StatUnbounded;
          pivot_row_q <= rfound_q ? best_row_q : '0;
          pivot_col_q <= best_col_q;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= StDone;
        end else begin
          rd_row_q <= rd_row_q + RW'(1);
          rd_col_q <= best_col_q;
          rd_en_q  <= 1'b1;
          state_q  <= StRrda;
        end
      end
    end
  end

  assign rd_en_o     = rd_en_q;
  assign rd_row_o    = rd_row_q;
  assign rd_col_o    = rd_col_q;
  assign div_req_o   = div_req_q;
  assign div_a_o     = div_a_q;
  assign div_b_o     = div_b_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign status_o    = status_q;
  assign pivot_row_o = pivot_row_q;
  assign pivot_col_o = pivot_col_q;

endmodule
